// File: rtl/led_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_seq
// Purpose  : 8-LED pattern sequencer with speed-selectable tick, four pattern
//            modes, run/freeze and single-step button control.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_seq #(
  parameter int BASE_DIV = 262144,
  parameter int CNT_W    = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step_btn,
  input  logic       mode_btn,
  input  logic [1:0] speed,
  output logic [7:0] shift_out,
  output logic       ctl_bit,
  output logic [1:0] mode,
  output logic       tick
);

  typedef enum logic [1:0] {
    M_BOUNCE = 2'd0,
    M_FILL   = 2'd1,
    M_BLINK  = 2'd2,
    M_CHASE  = 2'd3
  } mode_e;

  localparam logic c_DIR_RIGHT = 1'b0;
  localparam logic c_DIR_LEFT  = 1'b1;

  logic             r_step_ff1, r_step_ff2, r_step_prev;
  logic             r_mode_ff1, r_mode_ff2, r_mode_prev;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_pat;
  logic             r_dir;
  mode_e            r_mode;
  logic             r_ctl;

  logic             w_step_edge, w_mode_edge;
  logic [CNT_W-1:0] w_period;
  logic             w_tick, w_adv;
  logic [7:0]       w_step_pat;
  logic             w_step_dir;
  logic             w_dir_eff;
  logic [7:0]       w_shifted;
  logic [7:0]       w_inv;
  mode_e            w_mode_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [7:0]       w_pat_nxt;
  logic             w_dir_nxt;

  function automatic logic [7:0] init_pat(input mode_e m);
    case (m)
      M_BOUNCE: init_pat = 8'hE0;
      M_FILL:   init_pat = 8'h00;
      M_BLINK:  init_pat = 8'hAA;
      default:  init_pat = 8'h80;
    endcase
  endfunction

  assign w_step_edge = r_step_ff2 & ~r_step_prev;
  assign w_mode_edge = r_mode_ff2 & ~r_mode_prev;
  assign w_period    = CNT_W'(BASE_DIV) << speed;
  // Compare with >= so a speed decrease past the current count fires at once
  assign w_tick      = reset & run & (r_count >= (w_period - CNT_W'(1)));
  assign w_adv       = run ? w_tick : w_step_edge;

  // Pattern successor for the current mode; unreachable values restart the mode
  always_comb begin
    w_step_pat = init_pat(r_mode);
    w_step_dir = c_DIR_RIGHT;
    w_dir_eff  = r_dir;
    w_shifted  = r_pat;
    w_inv      = ~r_pat;
    case (r_mode)
      M_BOUNCE: begin
        if (r_pat == 8'hE0 || r_pat == 8'h70 || r_pat == 8'h38 ||
            r_pat == 8'h1C || r_pat == 8'h0E || r_pat == 8'h07) begin
          if (r_pat == 8'hE0)      w_dir_eff = c_DIR_RIGHT;
          else if (r_pat == 8'h07) w_dir_eff = c_DIR_LEFT;
          w_shifted  = (w_dir_eff == c_DIR_LEFT) ? (r_pat << 1) : (r_pat >> 1);
          w_step_pat = w_shifted;
          if (w_shifted == 8'h07)      w_step_dir = c_DIR_LEFT;
          else if (w_shifted == 8'hE0) w_step_dir = c_DIR_RIGHT;
          else                         w_step_dir = w_dir_eff;
        end
      end
      M_FILL: begin
        // Legal fill values are a run of ones from the MSB: ~pat is 0..01..1
        if ((w_inv & (w_inv + 8'd1)) == 8'h00)
          w_step_pat = (r_pat == 8'hFF) ? 8'h00 : {1'b1, r_pat[7:1]};
        w_step_dir = r_dir;
      end
      M_BLINK: begin
        w_step_pat = (r_pat == 8'hAA) ? 8'h55 : 8'hAA;
        w_step_dir = r_dir;
      end
      default: begin
        if ((r_pat != 8'h00) && ((r_pat & (r_pat - 8'd1)) == 8'h00))
          w_step_pat = {r_pat[0], r_pat[7:1]};
        w_step_dir = r_dir;
      end
    endcase
  end

  // Mode edge outranks any advance landing in the same cycle
  always_comb begin
    w_mode_nxt  = r_mode;
    w_count_nxt = r_count;
    w_pat_nxt   = r_pat;
    w_dir_nxt   = r_dir;
    if (w_mode_edge) begin
      w_mode_nxt  = mode_e'(r_mode + 2'd1);
      w_pat_nxt   = init_pat(mode_e'(r_mode + 2'd1));
      w_dir_nxt   = c_DIR_RIGHT;
      w_count_nxt = '0;
    end else begin
      if (!run || w_tick) w_count_nxt = '0;
      else                w_count_nxt = r_count + CNT_W'(1);
      if (w_adv) begin
        w_pat_nxt = w_step_pat;
        w_dir_nxt = w_step_dir;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_step_ff1  <= 1'b0;
      r_step_ff2  <= 1'b0;
      r_step_prev <= 1'b0;
      r_mode_ff1  <= 1'b0;
      r_mode_ff2  <= 1'b0;
      r_mode_prev <= 1'b0;
      r_count     <= '0;
      r_pat       <= 8'hE0;
      r_dir       <= c_DIR_RIGHT;
      r_mode      <= M_BOUNCE;
      r_ctl       <= 1'b0;
    end else begin
      r_step_ff1  <= step_btn;
      r_step_ff2  <= r_step_ff1;
      r_step_prev <= r_step_ff2;
      r_mode_ff1  <= mode_btn;
      r_mode_ff2  <= r_mode_ff1;
      r_mode_prev <= r_mode_ff2;
      r_count     <= w_count_nxt;
      r_pat       <= w_pat_nxt;
      r_dir       <= w_dir_nxt;
      r_mode      <= w_mode_nxt;
      r_ctl       <= 1'b1;
    end
  end

  assign shift_out = r_pat;
  assign ctl_bit   = r_ctl;
  assign mode      = r_mode;
  assign tick      = w_tick;

endmodule
`default_nettype wire

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
Programmable LED pattern sequencer that drives the 8-LED bar and its LED-driver enable. It replaces the fixed divider-plus-shifter pair with one controller. The controller contains a speed-selectable tick prescaler, four pattern modes, run/freeze control and single-step control. Buttons are raw board inputs; the block synchronises them and edge-detects them internally (no debounce).

Parameters:
BASE_DIV, 262144, clk cycles per tick at speed=0 (bench uses 4)
CNT_W, 22, prescaler width; must hold BASE_DIV*8-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
run  in  1  level; 1 = auto-advance on tick, 0 = frozen
step_btn  in  1  raw button; rising edge advances one step when run=0
mode_btn  in  1  raw button; rising edge selects next mode
speed  in  2  tick period = BASE_DIV << speed clk cycles
shift_out  out  8  LED pattern
ctl_bit  out  1  LED driver enable
mode  out  2  current mode
tick  out  1  one-cycle advance strobe (debug)

Behaviour:
- Reset (sampled reset=0 at posedge):
  - shift_out=8'hE0, dir=right, mode=0, count=0.
  - All sync/edge flops=0, ctl_bit=0.
  - tick=0 while reset=0.
  - Reset mid-operation forces these values at the next edge regardless of other inputs.
- ctl_bit: registered; 1 from the first edge after reset is released.
- Button path: ff1 -> ff2 -> prev; edge = ff2 & ~prev.
  - The effect is visible after the 3rd posedge, counting the edge that first samples the input high.
  - A button held high continuously yields exactly one edge.
  - A button held through reset yields one edge after release.
- Prescaler:
  - period = BASE_DIV << speed.
  - When run=1: tick = (count >= period-1), combinational from count. On tick, count <= 0; else count <= count+1.
  - A speed decrease while count >= new period-1 produces a tick in the next cycle.
  - When run=0: count held at 0, tick=0.
- Advance event = tick (run=1) or step edge (run=0). Step edges are ignored when run=1.
- Pattern steps on an advance event, updating at the same posedge that clears count:
  - Mode 0 BOUNCE: 3-bit bar shifted by dir, 10-step cycle E0,70,38,1C,0E,07,0E,1C,38,70,E0...
    - dir flips to left when the pattern reaches 07 and to right when it reaches E0. dir change and shift happen in the same step.
  - Mode 1 FILL: 00,80,C0,E0,F0,F8,FC,FE,FF,00... (9-step cycle).
  - Mode 2 BLINK: AA,55,AA...
  - Mode 3 CHASE: rotate right one-hot: 80,40,20,10,08,04,02,01,80...
- Mode edge:
  - mode <= mode+1 (wraps 3->0).
  - shift_out loaded with the new mode's initial value: E0/00/AA/80. BOUNCE also resets dir=right.
  - count <= 0.
- Priority: reset > mode edge > advance event. A mode edge in the same cycle as a tick or step discards the advance.
- An illegal pattern value (not reachable in the current mode) recovers to the mode's initial value on the next advance.

Test Plan:
1. Reset: reset=0 for 3 cycles with run=1 and buttons high.
   - During reset: shift_out=E0, mode=0, ctl_bit=0, tick=0.
   - After release: ctl_bit=1 on the first edge; one mode edge occurs (mode=1, shift_out=00 by the 3rd edge).
2. BOUNCE, BASE_DIV=4, speed=0, run=1:
   - tick is high every 4th cycle.
   - shift_out sequence: E0,70,38,1C,0E,07,0E,1C,38,70,E0,70.
3. Speed:
   - speed=2: ticks spaced 16 cycles.
   - Switch speed 3->0 while count=10: tick in the next cycle, then every 4 cycles.
4. Modes: press mode_btn repeatedly.
   - mode=1: shift_out=00, then under ticks 80,C0,...,FF,00.
   - mode=2: AA,55,AA.
   - mode=3: 80,40,...,01,80.
   - Next press: mode=0, E0.
5. Step:
   - run=0: shift_out frozen and tick=0 for 100 cycles.
   - Two separate step_btn pulses give exactly two advances.
   - step_btn held 50 cycles gives one advance.
   - Step pulses with run=1 have no extra effect.
6. Collision: mode edge arriving in the same cycle as a tick.
   - Result: initial pattern of the new mode, no advance.
   - The next tick occurs a full period later.
